// File: rtl/split_pkg.sv
// Shared types for the streamed split-constraint evaluator: fold modes, FSM states
// and the per-mode starting value of the running verdict.
package split_pkg;

    typedef enum logic [1:0] {
        MODE_TRUE   = 2'd0,
        MODE_ALL_NZ = 2'd1,
        MODE_ALL_LE = 2'd2,
        MODE_PARITY = 2'd3
    } split_mode_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    // Parity folds from an empty XOR; every other mode folds from an empty AND.
    function automatic logic acc_init(input split_mode_e mode);
        return (mode == MODE_PARITY) ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/split_term_eval.sv
// Combinational fold of one variable into the running frame verdict.
module split_term_eval
    import split_pkg::*;
#(
    parameter int MAX_W = 16
) (
    input  split_mode_e      mode,
    input  logic [MAX_W-1:0] limit,
    input  logic [MAX_W-1:0] data,
    input  logic             acc_in,
    output logic             acc_next
);

    // Per-mode verdict update for the current beat
    always_comb begin
        acc_next = acc_in;
        case (mode)
            MODE_TRUE:   acc_next = acc_in;
            MODE_ALL_NZ: acc_next = acc_in & (data != {MAX_W{1'b0}});
            MODE_ALL_LE: acc_next = acc_in & (data <= limit);
            MODE_PARITY: acc_next = acc_in ^ (^data);
            default:     acc_next = acc_in;
        endcase
    end

endmodule

// File: rtl/split_stream_eval.sv
// Streams NUM_VARS variables per frame over valid/ready, folds them into one verdict
// under the latched mode, and returns x (plus a framing error flag) on an out handshake.
module split_stream_eval
    import split_pkg::*;
#(
    parameter int NUM_VARS = 150,
    parameter int MAX_W    = 16,
    parameter int CNT_W    = $clog2(NUM_VARS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       cfg_mode,
    input  logic [MAX_W-1:0] cfg_limit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAX_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             x,
    output logic             err,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VARS - 1);

    state_e           state_r, state_s;
    split_mode_e      mode_r, mode_s;
    logic [MAX_W-1:0] limit_r, limit_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             acc_r, acc_s;
    logic             out_valid_r, out_valid_s;
    logic             x_r, x_s;
    logic             err_r, err_s;
    logic             in_ready_r, in_ready_s;
    logic             busy_r, busy_s;

    logic             beat_s;
    logic             final_s;
    logic             frame_err_s;
    logic             term_acc_s;

    split_term_eval #(
        .MAX_W (MAX_W)
    ) u_term (
        .mode     (mode_r),
        .limit    (limit_r),
        .data     (in_data),
        .acc_in   (acc_r),
        .acc_next (term_acc_s)
    );

    // A framing error is any disagreement between in_last and the expected final index
    assign beat_s      = in_valid & in_ready_r;
    assign final_s     = (cnt_r == LAST_IDX);
    assign frame_err_s = in_last ^ final_s;

    // Next-state, counter, config and result computation
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        limit_s     = limit_r;
        cnt_s       = cnt_r;
        acc_s       = acc_r;
        out_valid_s = out_valid_r;
        x_s         = x_r;
        err_s       = err_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_COLLECT;
                    mode_s  = split_mode_e'(cfg_mode);
                    limit_s = cfg_limit;
                    cnt_s   = {CNT_W{1'b0}};
                    acc_s   = acc_init(split_mode_e'(cfg_mode));
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (beat_s) begin
                    acc_s = term_acc_s;
                    if (in_last || final_s) begin
                        state_s     = S_DONE;
                        out_valid_s = 1'b1;
                        err_s       = frame_err_s;
                        x_s         = frame_err_s ? 1'b0 : term_acc_s;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = S_COLLECT;
                end
            end
            S_DONE: begin
                // x/err stay put after the handoff; only out_valid qualifies them
                if (out_ready) begin
                    state_s     = S_IDLE;
                    out_valid_s = 1'b0;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s     = S_IDLE;
                out_valid_s = 1'b0;
            end
        endcase
        in_ready_s = (state_s == S_COLLECT);
        busy_s     = (state_s != S_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            mode_r      <= MODE_TRUE;
            limit_r     <= {MAX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            acc_r       <= 1'b1;
            out_valid_r <= 1'b0;
            x_r         <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            limit_r     <= limit_s;
            cnt_r       <= cnt_s;
            acc_r       <= acc_s;
            out_valid_r <= out_valid_s;
            x_r         <= x_s;
            err_r       <= err_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign x         = x_r;
    assign err       = err_r;
    assign busy      = busy_r;

endmodule
